// File: rtl/ram_loader.sv
// Streams a burst of upstream words into a RAM32K-style port (address/in/load).
// Optional feature: define LOADER_CHECKSUM_EN to add a running modulo-2^DATA_W checksum output.
module ram_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;

    // s_ready and busy are registered copies of (state == LOAD).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            s_ready     <= 1'b0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            ram_load <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= word_count;
`ifdef LOADER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (word_count != '0) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        ram_in      <= s_data;
                        ram_address <= cur_addr;
                        ram_load    <= 1'b1;
                        cur_addr    <= cur_addr + ADDR_W'(1);
                        remaining   <= remaining - ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        checksum    <= checksum + s_data;
`endif
                        // done lines up with the write pulse of the final word
                        if (remaining == ADDR_W'(1)) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected writes queued on accept, checked on ram_load.
// Build with LOADER_CHECKSUM_EN defined to also check the checksum output.
module tb_ram_loader;
    localparam int AW = 15;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [DW-1:0] ram_in;
    logic          ram_load;
    logic [AW-1:0] ram_address;
    logic          busy;
    logic          done;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clock = ~clock;

    ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .busy        (busy),
`ifdef LOADER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .done        (done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            writes = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] sum_model = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor and behavioural RAM
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && ram_load) begin
            writes++;
            mem[ram_address] = ram_in;
            if (sb.size() == 0) begin
                check("spurious_load", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ram_address", 32'(ram_address), 32'(e.addr));
                check("ram_in", 32'(ram_in), 32'(e.data));
                check("done_with_last", 32'(done), 32'(e.last));
`ifdef LOADER_CHECKSUM_EN
                if (e.last) check("checksum", 32'(checksum), 32'(sum_model));
`endif
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
        @(negedge clock);
        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        sum_model = '0;
        writes = 0;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_word(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic last);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data = data;
        while (!s_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
        end
        sum_model = sum_model + data;
        sb.push_back('{addr: addr, data: data, last: last});
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] w1 [3];
    logic [DW-1:0] w2 [3];

    initial begin
        w1[0] = 16'hB555; w1[1] = 16'h1234; w1[2] = 16'hFFFF;
        w2[0] = 16'h8000; w2[1] = 16'h8001; w2[2] = 16'h0005;

        #1 reset_n = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_ram_load", 32'(ram_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_in", 32'(ram_in), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle_cycles(2);

        // Basic back-to-back burst, then start during DONE must be ignored
        do_start(15'h01C0, 15'd3);
        check("busy_in_load", 32'(busy), 32'd1);
        check("s_ready_in_load", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++)
            send_word(15'h01C0 + AW'(i), w1[i], i == 2);
        check("done_pulse", 32'(done), 32'd1);
        start = 1'b1;
        word_count = 15'd5;
        @(negedge clock);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("start_in_done_busy", 32'(busy), 32'd0);
        check("start_in_done_ready", 32'(s_ready), 32'd0);
        idle_cycles(3);
        check("burst1_writes", 32'(writes), 32'd3);
        for (int i = 0; i < 3; i++)
            check("burst1_readback", 32'(mem[15'h01C0 + AW'(i)]), 32'(w1[i]));
        check("burst1_sb_empty", 32'(sb.size()), 32'd0);

        // Same burst with a two-cycle gap after the first word
        do_start(15'h01C0, 15'd3);
        send_word(15'h01C0, w1[0], 1'b0);
        for (int g = 0; g < 2; g++) begin
            @(negedge clock);
            check("stall_no_load", 32'(ram_load), 32'd0);
            check("stall_addr_hold", 32'(ram_address), 32'h01C0);
            check("stall_ready", 32'(s_ready), 32'd1);
        end
        send_word(15'h01C1, w1[1], 1'b0);
        send_word(15'h01C2, w1[2], 1'b1);
        idle_cycles(3);
        check("stall_writes", 32'(writes), 32'd3);

        // Zero-length burst
        do_start(15'h0100, 15'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_ready", 32'(s_ready), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("zero_done_clear", 32'(done), 32'd0);
        check("zero_ready_after", 32'(s_ready), 32'd0);
        idle_cycles(2);
        check("zero_writes", 32'(writes), 32'd0);

        // Reset while the second word's write pulse is out
        do_start(15'h0200, 15'd4);
        send_word(15'h0200, 16'hA1A1, 1'b0);
        s_valid = 1'b1;
        s_data = 16'hA2A2;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ram_load", 32'(ram_load), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ram_address", 32'(ram_address), 32'd0);
        sb.delete();
        s_data = 16'hA3A3;
        @(negedge clock);
        reset_n = 1'b1;
        idle_cycles(4);
        check("midrst_s_ready_idle", 32'(s_ready), 32'd0);
        check("midrst_writes", 32'(writes), 32'd1);
        check("midrst_ram", 32'(mem[15'h0200]), 32'hA1A1);
        s_valid = 1'b0;

        // Address wrap at the top of the RAM
        do_start(15'h7FFF, 15'd2);
        send_word(15'h7FFF, 16'h5A5A, 1'b0);
        send_word(15'h0000, 16'hC3C3, 1'b1);
        idle_cycles(3);
        check("wrap_writes", 32'(writes), 32'd2);
        check("wrap_mem_top", 32'(mem[15'h7FFF]), 32'h5A5A);
        check("wrap_mem_zero", 32'(mem[15'h0000]), 32'hC3C3);

        // Checksum pattern (plain burst when the checksum is not built)
        do_start(15'h0010, 15'd3);
        for (int i = 0; i < 3; i++)
            send_word(15'h0010 + AW'(i), w2[i], i == 2);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_final", 32'(checksum), 32'h0006);
`endif
        idle_cycles(3);
        check("cks_writes", 32'(writes), 32'd3);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
